// File: rtl/vdp_sprite_line_renderer_pkg.sv
// Shared types and constants for the VDP sprite line renderer.
//   spr_row_t  : four bitplane bytes of one sprite row, [0]=plane0..[3]=plane3
//   spr_slot_t : one line-buffer slot (valid bit, X position, pattern row)
//   state_t    : renderer FSM states
package vdp_sprite_line_renderer_pkg;

  localparam int SPR_SLOTS    = 8;  // sprites per line (SMS limit)
  localparam int SPR_WIDTH    = 8;  // pixels per sprite row
  localparam int EC_SHIFT_PIX = 8;  // left shift applied by reg0 bit3

  typedef logic [3:0][7:0] spr_row_t;

  typedef struct packed {
    logic       valid;
    logic [7:0] hpos;
    spr_row_t   row;
  } spr_slot_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ACTIVE
  } state_t;

endpackage

// File: rtl/vdp_sprite_slot_pixel.sv
// Combinational hit test and colour extraction for one sprite slot.
// Ports:
//   slot     : slot contents (valid, hpos, bitplanes)
//   pix_x    : SMS pixel X being rendered
//   ec_shift : shift sprite 8 pixels left
//   hit      : pixel lies inside this slot's 8-pixel span
//   color    : 4-bit colour index from the bitplanes (meaningful when hit)
module vdp_sprite_slot_pixel
  import vdp_sprite_line_renderer_pkg::*;
(
  input  spr_slot_t   slot,
  input  logic [7:0]  pix_x,
  input  logic        ec_shift,
  output logic        hit,
  output logic [3:0]  color
);

  logic [9:0] d;
  logic [2:0] b;

  // Offset into the sprite; a pixel left of hpos wraps to a large unsigned
  // value, so a single unsigned compare covers 0 <= d <= 7 with no X wrap.
  assign d = {2'b00, pix_x} + (ec_shift ? 10'(EC_SHIFT_PIX) : 10'd0)
           - {2'b00, slot.hpos};

  assign hit = slot.valid && (d < 10'(SPR_WIDTH));

  // Leftmost pixel comes from the MSB of each plane byte.
  assign b     = 3'd7 - d[2:0];
  assign color = {slot.row[3][b], slot.row[2][b], slot.row[1][b], slot.row[0][b]};

endmodule

// File: rtl/vdp_sprite_line_renderer.sv
// Sprite line buffer and pixel renderer. Captures up to 8 sprite pattern
// rows for the next scanline, then emits the winning sprite colour per SMS
// pixel with priority and collision detection, and holds the sticky
// collision/overflow status bits.
// Ports:
//   clk, rst                  : clock, async active-high reset
//   line_start                : restart line (clears slot valid bits, -> LOAD)
//   load_valid/ready, load_*  : slot load handshake and payload
//   ec_shift                  : early-clock shift of all sprites by 8 pixels
//   pix_valid, pix_x          : pixel strobe and its X
//   spr_valid/color/opaque    : registered pixel result, 1 cycle after strobe
//   overflow_in, status_clr   : status set/clear pulses
//   collision_flag/overflow_flag : sticky status bits
//   state                     : current FSM state (debug)
//
// Handshake: a load transfers on any rising clk edge where load_valid and
// load_ready are both high; load_ready is high only in LOAD without a
// concurrent line_start, and does not depend on load_valid.
module vdp_sprite_line_renderer
  import vdp_sprite_line_renderer_pkg::*;
#(
  parameter int NUM_SLOTS = SPR_SLOTS,
  parameter int PIX_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             line_start,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [2:0]       load_idx,
  input  logic [7:0]       load_hpos,
  input  spr_row_t         load_row,
  input  logic             ec_shift,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix_x,
  output logic             spr_valid,
  output logic [3:0]       spr_color,
  output logic             spr_opaque,
  input  logic             overflow_in,
  input  logic             status_clr,
  output logic             collision_flag,
  output logic             overflow_flag,
  output state_t           state
);

  state_t    state_q, state_d;
  spr_slot_t slots_q [NUM_SLOTS];

  logic [NUM_SLOTS-1:0] slot_hit;
  logic [3:0]           slot_color [NUM_SLOTS];
  logic [3:0]           win_color;
  logic                 win_found;
  logic                 multi;
  logic                 coll_event;
  logic                 last_pix;

  assign state      = state_q;
  assign load_ready = (state_q == LOAD) && !line_start;
  assign last_pix   = pix_valid && (pix_x == {PIX_W{1'b1}});

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    vdp_sprite_slot_pixel u_pix (
      .slot     (slots_q[g]),
      .pix_x    (pix_x),
      .ec_shift (ec_shift),
      .hit      (slot_hit[g]),
      .color    (slot_color[g])
    );
  end

  // Lowest-numbered opaque hit wins; any further opaque hit is a collision.
  always_comb begin
    win_color = 4'd0;
    win_found = 1'b0;
    multi     = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (slot_hit[i] && (slot_color[i] != 4'd0)) begin
        if (win_found) begin
          multi = 1'b1;
        end else begin
          win_color = slot_color[i];
          win_found = 1'b1;
        end
      end
    end
  end

  assign coll_event = (state_q == ACTIVE) && pix_valid && multi;

  always_comb begin
    state_d = state_q;
    if (line_start) begin
      state_d = LOAD;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        LOAD:    if (pix_valid && (pix_x == '0)) state_d = ACTIVE;
        ACTIVE:  if (last_pix) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Slot storage: line_start only drops valid bits; positions and patterns
  // stay until overwritten by a load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) slots_q[i] <= '0;
    end else if (line_start) begin
      for (int i = 0; i < NUM_SLOTS; i++) slots_q[i].valid <= 1'b0;
    end else if (load_valid && load_ready) begin
      slots_q[load_idx] <= '{valid: 1'b1, hpos: load_hpos, row: load_row};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spr_valid  <= 1'b0;
      spr_color  <= 4'd0;
      spr_opaque <= 1'b0;
    end else begin
      spr_valid <= pix_valid;
      if (pix_valid) begin
        spr_color  <= win_color;
        spr_opaque <= win_found;
      end
    end
  end

  // Set has priority over a coincident clear so no event is lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      collision_flag <= 1'b0;
      overflow_flag  <= 1'b0;
    end else begin
      if (coll_event)      collision_flag <= 1'b1;
      else if (status_clr) collision_flag <= 1'b0;
      if (overflow_in)     overflow_flag  <= 1'b1;
      else if (status_clr) overflow_flag  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vdp_sprite_line_renderer.sv
module tb_vdp_sprite_line_renderer;
  import vdp_sprite_line_renderer_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             line_start = 1'b0;
  logic             load_valid = 1'b0;
  logic             load_ready;
  logic [2:0]       load_idx   = 3'd0;
  logic [7:0]       load_hpos  = 8'd0;
  logic [3:0][7:0]  load_row   = '0;
  logic             ec_shift   = 1'b0;
  logic             pix_valid  = 1'b0;
  logic [7:0]       pix_x      = 8'd0;
  logic             spr_valid;
  logic [3:0]       spr_color;
  logic             spr_opaque;
  logic             overflow_in = 1'b0;
  logic             status_clr  = 1'b0;
  logic             collision_flag;
  logic             overflow_flag;
  state_t           state;

  vdp_sprite_line_renderer dut (
    .clk            (clk),
    .rst            (rst),
    .line_start     (line_start),
    .load_valid     (load_valid),
    .load_ready     (load_ready),
    .load_idx       (load_idx),
    .load_hpos      (load_hpos),
    .load_row       (load_row),
    .ec_shift       (ec_shift),
    .pix_valid      (pix_valid),
    .pix_x          (pix_x),
    .spr_valid      (spr_valid),
    .spr_color      (spr_color),
    .spr_opaque     (spr_opaque),
    .overflow_in    (overflow_in),
    .status_clr     (status_clr),
    .collision_flag (collision_flag),
    .overflow_flag  (overflow_flag),
    .state          (state)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_valid [8];
  int          m_hpos  [8];
  logic [31:0] m_row   [8];
  bit          b_load   = 1'b0;
  bit          b_active = 1'b0;
  bit          exp_coll = 1'b0;

  // Sprite occupies screen columns [left, left+7]; column left shows MSB.
  function automatic void model(input int x, input bit ec, output logic [3:0] col,
                                output bit opq, output int nopq);
    col = 4'd0; opq = 1'b0; nopq = 0;
    for (int s = 0; s < 8; s++) begin
      if (m_valid[s]) begin
        int left;
        left = m_hpos[s] - (ec ? 8 : 0);
        if (x >= left && x <= left + 7) begin
          int bi;
          logic [3:0] c;
          bi = 7 - (x - left);
          c = {m_row[s][24+bi], m_row[s][16+bi], m_row[s][8+bi], m_row[s][bi]};
          if (c != 4'd0) begin
            nopq++;
            if (!opq) begin
              col = c;
              opq = 1'b1;
            end
          end
        end
      end
    end
  endfunction

  // scoreboard item: {x[7:0], color[3:0], opaque, collision_flag}
  logic [13:0] exp_q[$];

  always @(negedge clk) begin
    if (!rst && spr_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_spr_valid", 32'd1, 32'd0);
      end else begin
        logic [13:0] it;
        it = exp_q.pop_front();
        check($sformatf("pix x=%0d", it[13:6]), {27'd0, spr_color, spr_opaque}, {27'd0, it[5:1]});
        check($sformatf("coll x=%0d", it[13:6]), {31'd0, collision_flag}, {31'd0, it[0]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_line_start();
    @(negedge clk);
    line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
    for (int s = 0; s < 8; s++) m_valid[s] = 1'b0;
    b_load   = 1'b1;
    b_active = 1'b0;
  endtask

  task automatic load_slot(input int idx, input int hp, input logic [31:0] row);
    @(negedge clk);
    load_valid = 1'b1;
    load_idx   = idx[2:0];
    load_hpos  = hp[7:0];
    load_row   = row;
    #1;
    check($sformatf("load_ready idx=%0d", idx), {31'd0, load_ready}, {31'd0, b_load});
    if (b_load) begin
      m_valid[idx] = 1'b1;
      m_hpos[idx]  = hp;
      m_row[idx]   = row;
    end
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic strobe(input int x, input bit clr);
    logic [3:0] c;
    bit o;
    int n;
    @(negedge clk);
    pix_valid  = 1'b1;
    pix_x      = x[7:0];
    status_clr = clr;
    model(x, ec_shift, c, o, n);
    if (n >= 2 && b_active) exp_coll = 1'b1;
    else if (clr)           exp_coll = 1'b0;
    if (x == 0 && b_load) begin
      b_load   = 1'b0;
      b_active = 1'b1;
    end else if (x == 255 && b_active) begin
      b_active = 1'b0;
    end
    exp_q.push_back({x[7:0], c, o, exp_coll});
    @(negedge clk);
    pix_valid  = 1'b0;
    status_clr = 1'b0;
  endtask

  task automatic sweep(input int clr_at);
    for (int x = 0; x < 256; x++) strobe(x, x == clr_at);
  endtask

  task automatic clear_status();
    @(negedge clk);
    status_clr = 1'b1;
    @(negedge clk);
    status_clr = 1'b0;
    exp_coll = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int s = 0; s < 8; s++) begin
      m_valid[s] = 1'b0; m_hpos[s] = 0; m_row[s] = '0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("state_after_reset", 32'(state), 32'(IDLE));
    check("load_ready_idle", {31'd0, load_ready}, 32'd0);

    // Reset asserted mid-ACTIVE with slot 0 loaded and flags set.
    do_line_start();
    load_slot(0, 0, 32'h0000_00FF);
    @(negedge clk); overflow_in = 1'b1;
    @(negedge clk); overflow_in = 1'b0;
    strobe(0, 1'b0);
    @(negedge clk);
    pix_valid = 1'b1; pix_x = 8'd1;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_spr_valid", {31'd0, spr_valid}, 32'd0);
    check("rst_spr_color", {28'd0, spr_color}, 32'd0);
    check("rst_spr_opaque", {31'd0, spr_opaque}, 32'd0);
    check("rst_overflow", {31'd0, overflow_flag}, 32'd0);
    check("rst_collision", {31'd0, collision_flag}, 32'd0);
    check("rst_state", 32'(state), 32'(IDLE));
    pix_valid = 1'b0;
    exp_q.delete();
    for (int s = 0; s < 8; s++) m_valid[s] = 1'b0;
    b_load = 1'b0; b_active = 1'b0; exp_coll = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    strobe(0, 1'b0);

    // Single sprite; first load to slot 0 is overwritten by the second.
    do_line_start();
    load_slot(0, 200, 32'h0000_00FF);
    load_slot(0, 16, 32'h0000_00FF);
    sweep(-1);

    // Early-clock shift.
    ec_shift = 1'b1;
    do_line_start();
    load_slot(0, 16, 32'h0000_00FF);
    sweep(-1);
    ec_shift = 1'b0;

    // Right edge, no wrap.
    do_line_start();
    load_slot(0, 252, 32'h0000_00FF);
    sweep(-1);

    // Load while ACTIVE is refused and does not disturb output.
    do_line_start();
    load_slot(0, 50, 32'h0000_00FF);
    strobe(0, 1'b0);
    check("state_active", 32'(state), 32'(ACTIVE));
    load_slot(0, 60, 32'hFFFF_FFFF);
    for (int x = 1; x < 256; x++) strobe(x, 1'b0);
    check("state_idle_after_line", 32'(state), 32'(IDLE));

    // Transparent pixels of slot 1 over opaque slot 3: no collision.
    do_line_start();
    load_slot(1, 100, 32'h0000_000F);
    load_slot(3, 96, 32'h00FF_FF00);
    sweep(-1);

    // Overlap of slot 2 (colour 5) and slot 5 (colour 9) with clear during collision.
    do_line_start();
    load_slot(2, 40, 32'h00FF_00FF);
    load_slot(5, 44, 32'hFF00_00FF);
    sweep(45);
    check("coll_sticky", {31'd0, collision_flag}, 32'd1);

    // Overflow set, then clear alone, then set-vs-clear priority.
    @(negedge clk); overflow_in = 1'b1;
    @(negedge clk); overflow_in = 1'b0;
    check("ovf_set", {31'd0, overflow_flag}, 32'd1);
    clear_status();
    check("clr_collision", {31'd0, collision_flag}, 32'd0);
    check("clr_overflow", {31'd0, overflow_flag}, 32'd0);
    @(negedge clk); overflow_in = 1'b1; status_clr = 1'b1;
    @(negedge clk); overflow_in = 1'b0; status_clr = 1'b0;
    check("ovf_set_wins", {31'd0, overflow_flag}, 32'd1);

    // Random pattern line.
    do_line_start();
    for (int s = 0; s < 8; s++) load_slot(s, $urandom_range(0, 255), $urandom());
    clear_status();
    sweep(-1);

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    n_errors++;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vdp_sprite_line_renderer.md
Name: vdp_sprite_line_renderer

Overview:
Downstream stage of the sprite evaluation/fetch logic. It captures up to 8 sprite pattern rows (4 bitplane bytes plus X position each) for the next scanline. During the active line it emits the sprite colour for each SMS pixel, resolving priority and detecting collision. It also holds the sticky collision and overflow status bits that the VDP status register reports.

Parameters:
NUM_SLOTS, 8, sprite slots per line (fixed at the SMS limit)
PIX_W, 8, SMS pixel X width (256 pixels per line)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
line_start  in  1  one-cycle pulse before sprite evaluation of a new line
load_valid  in  1  pattern-row load request
load_ready  out  1  load accepted when load_valid && load_ready
load_idx  in  3  destination slot
load_hpos  in  8  sprite X position (SAT HPOS byte)
load_row  in  4x8  bitplane bytes [0]=plane0..[3]=plane3 for this line's sprite row
ec_shift  in  1  reg0 bit3; shifts all sprites 8 pixels left
pix_valid  in  1  strobe, one per SMS pixel (every second VGA column)
pix_x  in  8  SMS pixel X of the strobe
spr_valid  out  1  registered pix_valid
spr_color  out  4  winning sprite colour index (palette 16..31 selected downstream)
spr_opaque  out  1  winning colour is non-zero
overflow_in  in  1  pulse: evaluator found a 9th sprite on the line
status_clr  in  1  pulse: CPU read of status register
collision_flag  out  1  sticky sprite-collision status bit
overflow_flag  out  1  sticky sprite-overflow status bit

Behaviour:
- Reset: state IDLE; all slot valid bits, hpos and pattern bytes 0; spr_valid, spr_color, spr_opaque, collision_flag and overflow_flag all 0; load_ready 0.
- FSM states are IDLE, LOAD and ACTIVE.
  - IDLE -> LOAD on line_start.
  - LOAD -> ACTIVE on pix_valid && pix_x==0.
  - ACTIVE -> IDLE on the cycle after pix_valid && pix_x==255.
  - line_start in any state: clear all slot valid bits and go to LOAD. This is how mid-line aborts and restarts are handled.
- load_ready = (state==LOAD) && !line_start.
  - An accepted load writes the slot's hpos and pattern bytes and sets its valid bit.
  - Reloading the same slot overwrites it; the last write wins.
  - Loads presented in IDLE or ACTIVE are not accepted; the slot is unchanged.
- Per-slot hit, computed combinationally each pix_valid:
  - d = {2'b0,pix_x} + (ec_shift ? 10'd8 : 10'd0) - {2'b0,hpos}, as 10-bit two's complement.
  - hit iff valid && 0 <= d <= 7.
  - bit index b = 7 - d[2:0]; colour = {plane3[b],plane2[b],plane1[b],plane0[b]}.
  - No horizontal wrap: hpos 252 covers pixels 252..255 only.
- Priority: the lowest-numbered slot with a hit and non-zero colour wins. If no slot qualifies, spr_color=0 and spr_opaque=0.
- Collision: two or more slots hit with non-zero colour on the same pixel.
- Latency: outputs are registered, one cycle after the pix_valid strobe.
  - spr_valid = pix_valid delayed by 1.
  - spr_color and spr_opaque update only on pix_valid cycles and hold otherwise.
- Collision is evaluated only while state==ACTIVE and pix_valid.
- Status flags:
  - collision_flag sets on a collision event.
  - overflow_flag sets on overflow_in in any state.
  - Both clear on status_clr.
  - If a set and status_clr occur in the same cycle, set wins.
- Slot contents persist through ACTIVE and IDLE until the next line_start.

Decomposition:
- Shared vdp package:
  - typedef spr_row_t (4x8 bitplanes)
  - typedef spr_slot_t {valid, hpos[7:0], spr_row_t}
  - state enum {IDLE, LOAD, ACTIVE}
  - constants SPR_SLOTS=8, SPR_WIDTH=8, EC_SHIFT_PIX=8
- One sub-module, vdp_sprite_slot_pixel: combinational hit test and colour extraction for one slot, instantiated 8 times via generate.
- Priority, collision, FSM and status registers live in the top module.

Test Plan:
- Reset asserted mid-ACTIVE with slot 0 loaded -> all outputs 0 and state IDLE immediately; after release, a strobe at pix_x=0 gives spr_valid=1 and spr_opaque=0.
- line_start; load slot 0 with hpos=16, planes {FF,00,00,00}; sweep pix_x 0..255 -> spr_color=1 and spr_opaque=1 exactly for x=16..23, one cycle after each strobe.
- Same load plus ec_shift=1 -> opaque for x=8..15. hpos=252 -> opaque for x=252..255 only, nothing at x=0..3.
- Slot 2 (hpos=40, colour 5) and slot 5 (hpos=44, colour 9) -> x=44..47 gives colour 5, x=48..51 gives colour 9; collision_flag=1 from the x=44 result. status_clr coincident with a further collision -> flag stays 1.
- Slot 1 with planes {0F,00,00,00} overlapping an opaque slot 3 on its transparent pixels -> slot 3's colour shown and no collision.
- Load presented while ACTIVE -> load_ready=0 and output unchanged. overflow_in pulse -> overflow_flag=1; status_clr alone -> both flags 0 next cycle.
